// File: rtl/locked_irq_arbiter.sv
// Keyed priority interrupt arbiter: edge-detected pending bits, lowest-index grant
// via valid/ack, with request decoding and grant ID obfuscated by a committed key.
module locked_irq_arbiter #(
  parameter int                NUM_CH       = 27,
  parameter int                KEY_W        = 32,
  parameter logic [KEY_W-1:0]  KEY_POLARITY = 32'hA5C3_0F96,
  localparam int               IDW          = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq_req,
  input  logic [NUM_CH-1:0] irq_en,
  input  logic              key_sdi,
  input  logic              key_shift,
  input  logic              key_commit,
  input  logic              irq_ack,
  output logic              irq_valid,
  output logic [IDW-1:0]    irq_id,
  output logic              key_loaded,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [KEY_W-1:0]  shadow_key;
  logic [KEY_W-1:0]  active_key;
  logic [KEY_W-1:0]  d;
  logic [NUM_CH-1:0] eff;
  logic [NUM_CH-1:0] eff_q;
  logic [NUM_CH-1:0] set_mask;
  logic [NUM_CH-1:0] clr_mask;
  logic [NUM_CH-1:0] pending_next;
  logic [NUM_CH-1:0] avail;
  logic [IDW-1:0]    grant_ch;
  logic [IDW-1:0]    low_idx;
  logic [IDW-1:0]    id_mask;

  assign d = active_key ^ KEY_POLARITY;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign eff[gi]      = irq_req[gi] ^ d[gi];
    assign set_mask[gi] = eff[gi] & ~eff_q[gi] & irq_en[gi];
    assign clr_mask[gi] = (state == GRANT) && irq_ack && (grant_ch == IDW'(gi));
  end

  // A new edge on the channel being acknowledged re-pends it.
  assign pending_next = (pending & ~clr_mask) | set_mask;
  assign avail        = pending & irq_en;

  if (KEY_W >= NUM_CH + IDW) begin : g_mask
    assign id_mask = d[NUM_CH +: IDW];
  end else begin : g_nomask
    assign id_mask = '0;
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (avail[i]) low_idx = IDW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_key <= '0;
      active_key <= '0;
      eff_q      <= '0;
      pending    <= '0;
      state      <= IDLE;
      grant_ch   <= '0;
      irq_valid  <= 1'b0;
      irq_id     <= '0;
      key_loaded <= 1'b0;
    end else begin
      if (key_shift) shadow_key <= {shadow_key[KEY_W-2:0], key_sdi};
      eff_q <= eff;

      if (key_commit) begin
        // Commit samples the shadow before this edge's shift and aborts any grant.
        active_key <= shadow_key;
        key_loaded <= 1'b1;
        pending    <= '0;
        state      <= IDLE;
        irq_valid  <= 1'b0;
      end else begin
        pending <= pending_next;
        case (state)
          IDLE: begin
            if (|avail) begin
              grant_ch  <= low_idx;
              irq_valid <= 1'b1;
              irq_id    <= low_idx ^ id_mask;
              state     <= GRANT;
            end
          end
          GRANT: begin
            if (irq_ack) begin
              irq_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_locked_irq_arbiter.sv
// Directed bench for locked_irq_arbiter: an edge-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_locked_irq_arbiter;

  localparam int          N   = 27;
  localparam int          KW  = 32;
  localparam int          IW  = 5;
  localparam logic [31:0] POL = 32'hA5C3_0F96;
  localparam logic [N-1:0] ALL = {N{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_req = '0;
  logic [N-1:0]  irq_en = '0;
  logic          key_sdi = 1'b0;
  logic          key_shift = 1'b0;
  logic          key_commit = 1'b0;
  logic          irq_ack = 1'b0;
  logic          irq_valid;
  logic [IW-1:0] irq_id;
  logic          key_loaded;
  logic [N-1:0]  pending;

  int total = 0;
  int bad = 0;

  locked_irq_arbiter #(.NUM_CH(N), .KEY_W(KW), .KEY_POLARITY(POL)) dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .irq_en(irq_en),
    .key_sdi(key_sdi), .key_shift(key_shift), .key_commit(key_commit),
    .irq_ack(irq_ack), .irq_valid(irq_valid), .irq_id(irq_id),
    .key_loaded(key_loaded), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what each edge must do to keys, pending set and the grant.
  logic [31:0]   m_shadow = '0, m_active = '0;
  logic          m_loaded = 1'b0, m_valid = 1'b0;
  logic [N-1:0]  m_pend = '0, m_prev = '0;
  logic [IW-1:0] m_id = '0;
  int            m_ch = 0;

  task automatic model_step();
    logic [31:0]  dd;
    logic [N-1:0] eff, rises;
    int pick;
    if (rst) begin
      m_shadow = '0; m_active = '0; m_loaded = 1'b0; m_valid = 1'b0;
      m_pend = '0; m_prev = '0; m_id = '0; m_ch = 0;
    end else begin
      dd    = m_active ^ POL;
      eff   = irq_req ^ dd[N-1:0];
      rises = eff & ~m_prev & irq_en;
      if (key_commit) begin
        m_active = m_shadow;
        m_loaded = 1'b1;
        m_pend   = '0;
        m_valid  = 1'b0;
      end else if (m_valid) begin
        if (irq_ack) begin
          m_pend[m_ch] = 1'b0;
          m_valid = 1'b0;
        end
        m_pend = m_pend | rises;
      end else begin
        pick = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && irq_en[i]) pick = i;
        if (pick >= 0) begin
          m_ch    = pick;
          m_valid = 1'b1;
          m_id    = IW'(pick) ^ dd[31:27];
        end
        m_pend = m_pend | rises;
      end
      if (key_shift) m_shadow = {m_shadow[30:0], key_sdi};
      m_prev = eff;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  always @(negedge clk) begin
    check("cyc_valid", 64'(irq_valid), 64'(m_valid));
    check("cyc_id", 64'(irq_id), 64'(m_id));
    check("cyc_loaded", 64'(key_loaded), 64'(m_loaded));
    check("cyc_pending", 64'(pending), 64'(m_pend));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_key(input logic [31:0] k);
    for (int i = 31; i >= 0; i--) begin
      key_sdi = k[i];
      key_shift = 1'b1;
      tick();
    end
    key_shift = 1'b0;
    key_sdi = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    check("rst_loaded", 64'(key_loaded), 64'd0);
    rst = 1'b0;
    tick();

    // Correct key, two simultaneous requests
    shift_key(POL);
    commit();
    check("a_loaded", 64'(key_loaded), 64'd1);
    irq_en = ALL;
    tick();
    irq_req = (N'(1) << 5) | (N'(1) << 3);
    tick();
    check("a_pend", 64'(pending), 64'h28);
    check("a_nogrant", 64'(irq_valid), 64'd0);
    tick();
    check("a_valid1", 64'(irq_valid), 64'd1);
    check("a_id3", 64'(irq_id), 64'd3);
    $display("txn: correct key grant id=%0d", irq_id);
    ack();
    check("a_gap", 64'(irq_valid), 64'd0);
    check("a_pend5", 64'(pending), 64'h20);
    tick();
    check("a_id5", 64'(irq_id), 64'd5);
    check("a_valid2", 64'(irq_valid), 64'd1);
    $display("txn: correct key grant id=%0d", irq_id);
    ack();
    check("a_pend0", 64'(pending), 64'd0);
    irq_req = '0;
    tick();

    // Masking: pending[2] is retained while disabled
    irq_req = (N'(1) << 2) | (N'(1) << 7);
    tick();
    irq_en = ALL & ~(N'(1) << 2);
    irq_req = '0;
    tick();
    check("m_id7", 64'(irq_id), 64'd7);
    check("m_pend", 64'(pending), 64'h84);
    $display("txn: masked grant id=%0d", irq_id);
    ack();
    check("m_pend2", 64'(pending), 64'h04);
    tick();
    check("m_held", 64'(irq_valid), 64'd0);
    irq_en = ALL;
    tick();
    check("m_id2", 64'(irq_id), 64'd2);
    check("m_valid2", 64'(irq_valid), 64'd1);
    $display("txn: unmasked grant id=%0d", irq_id);
    ack();
    tick();

    // Set and clear of the same bit at the ack edge
    irq_req = N'(1);
    tick(); tick();
    check("s_id0", 64'(irq_id), 64'd0);
    irq_req = '0;
    tick();
    irq_req = N'(1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("s_pend0", 64'(pending), 64'd1);
    check("s_gap", 64'(irq_valid), 64'd0);
    tick();
    check("s_regrant", 64'(irq_valid), 64'd1);
    check("s_id0b", 64'(irq_id), 64'd0);
    $display("txn: re-pended grant id=%0d", irq_id);
    ack();
    irq_req = '0;
    tick();

    // Commit mid-grant, then commit together with a shift
    irq_req = N'(1) << 4;
    tick(); tick();
    check("c_id4", 64'(irq_id), 64'd4);
    commit();
    check("c_abort", 64'(irq_valid), 64'd0);
    check("c_clear", 64'(pending), 64'd0);
    $display("txn: commit aborted grant");
    irq_req = '0;
    tick();
    key_commit = 1'b1; key_shift = 1'b1; key_sdi = 1'b1;
    tick();
    key_commit = 1'b0; key_shift = 1'b0; key_sdi = 1'b0;
    tick();
    irq_req = N'(1) << 6;
    tick(); tick();
    check("c_id6", 64'(irq_id), 64'd6);
    check("c_valid6", 64'(irq_valid), 64'd1);
    $display("txn: pre-shift key grant id=%0d", irq_id);
    ack();
    irq_req = '0;
    tick();

    // Wrong key: spurious interrupts and a masked ID
    shift_key(32'd0);
    commit();
    tick();
    check("w_pend", 64'(pending), 64'h5C30F96);
    check("w_idle", 64'(irq_valid), 64'd0);
    tick();
    check("w_valid", 64'(irq_valid), 64'd1);
    check("w_id21", 64'(irq_id), 64'd21);
    $display("txn: wrong key grant id=%0d", irq_id);

    // Asynchronous reset mid-grant
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("r_valid", 64'(irq_valid), 64'd0);
    check("r_id", 64'(irq_id), 64'd0);
    check("r_pend", 64'(pending), 64'd0);
    check("r_loaded", 64'(key_loaded), 64'd0);
    tick(); tick();
    check("r_hold", 64'(pending), 64'd0);
    $display("txn: async reset cleared outputs");
    rst = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
